// File: rtl/risc_spm_pkg.sv
// Shared constants for the RISC_SPM control unit: opcodes, FSM states, bus mux codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_spm_pkg;

  // Opcodes live in instruction[7:4].
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // 12 states in a 4-bit register; codes 12..15 are unreachable and fall into S_HALT.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // Bus_1 sources: register file occupies codes 0..3 so a register index maps directly.
  localparam logic [2:0] SEL_R0 = 3'd0;
  localparam logic [2:0] SEL_R1 = 3'd1;
  localparam logic [2:0] SEL_R2 = 3'd2;
  localparam logic [2:0] SEL_R3 = 3'd3;
  localparam logic [2:0] SEL_PC = 3'd4;

  // Bus_2 sources.
  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_BUS1 = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;

endpackage

// File: rtl/risc_spm_ctrl.sv
// Control-unit FSM for the RISC_SPM datapath: fetch, decode, execute one instruction per pass.
// Latency: NOP/NOT/untaken BRZ 3 cycles, ALU ops 4, RD/WR/BR/taken BRZ 5 (fetch included).
// Backpressure: none; memory is combinational, the FSM never stalls. Illegal opcode halts until reset.
//
// Ports: clk, rst (async, active-low); instruction (IR), zero (registered Zflag) in;
//   Load_R0..R3, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z,
//   Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted out.
// Optional: define RISC_CTRL_ICOUNT_EN to add the instr_count retired-instruction counter.
module risc_spm_ctrl
  import risc_spm_pkg::*;
#(
  parameter int word_size = 8,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
`ifdef RISC_CTRL_ICOUNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 write,
  output logic                 halted
`ifdef RISC_CTRL_ICOUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [3:0] load_r;

  assign opcode = instruction[word_size-1 -: 4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  assign Load_R0 = load_r[0];
  assign Load_R1 = load_r[1];
  assign Load_R2 = load_r[2];
  assign Load_R3 = load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_r        = 4'b0000;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    write         = 1'b0;
    halted        = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FET1;

      S_FET1: begin
        Sel_Bus_1_Mux = Sel1_size'(SEL_PC);
        Sel_Bus_2_Mux = Sel2_size'(SEL_BUS1);
        Load_Add_R    = 1'b1;
        state_nxt     = S_FET2;
      end

      S_FET2: begin
        Sel_Bus_2_Mux = Sel2_size'(SEL_MEM);
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        state_nxt     = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: state_nxt = S_FET1;

          OP_ADD, OP_SUB, OP_AND: begin
            // First operand parks in Y; the ALU combines it with the dest register in S_EX1.
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = Sel2_size'(SEL_BUS1);
            Load_Reg_Y    = 1'b1;
            state_nxt     = S_EX1;
          end

          OP_NOT: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            Sel_Bus_2_Mux = Sel2_size'(SEL_ALU);
            Load_Reg_Z    = 1'b1;
            load_r[dest]  = 1'b1;
            state_nxt     = S_FET1;
          end

          OP_RD, OP_WR, OP_BR: begin
            // PC already points at the operand word; latch it as the next address.
            Sel_Bus_1_Mux = Sel1_size'(SEL_PC);
            Sel_Bus_2_Mux = Sel2_size'(SEL_BUS1);
            Load_Add_R    = 1'b1;
            state_nxt     = (opcode == OP_RD) ? S_RD1 :
                            (opcode == OP_WR) ? S_WR1 : S_BR1;
          end

          OP_BRZ: begin
            if (zero) begin
              Sel_Bus_1_Mux = Sel1_size'(SEL_PC);
              Sel_Bus_2_Mux = Sel2_size'(SEL_BUS1);
              Load_Add_R    = 1'b1;
              state_nxt     = S_BR1;
            end else begin
              // Not taken: step PC over the operand word.
              Inc_PC    = 1'b1;
              state_nxt = S_FET1;
            end
          end

          default: state_nxt = S_HALT;
        endcase
      end

      S_EX1: begin
        Sel_Bus_1_Mux = Sel1_size'(dest);
        Sel_Bus_2_Mux = Sel2_size'(SEL_ALU);
        Load_Reg_Z    = 1'b1;
        load_r[dest]  = 1'b1;
        state_nxt     = S_FET1;
      end

      S_RD1, S_WR1: begin
        Sel_Bus_2_Mux = Sel2_size'(SEL_MEM);
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_nxt     = (state == S_RD1) ? S_RD2 : S_WR2;
      end

      S_RD2: begin
        Sel_Bus_2_Mux = Sel2_size'(SEL_MEM);
        load_r[dest]  = 1'b1;
        state_nxt     = S_FET1;
      end

      S_WR2: begin
        Sel_Bus_1_Mux = Sel1_size'(src);
        write         = 1'b1;
        state_nxt     = S_FET1;
      end

      S_BR1: begin
        Sel_Bus_2_Mux = Sel2_size'(SEL_MEM);
        Load_Add_R    = 1'b1;
        state_nxt     = S_BR2;
      end

      S_BR2: begin
        Sel_Bus_2_Mux = Sel2_size'(SEL_MEM);
        Load_PC       = 1'b1;
        state_nxt     = S_FET1;
      end

      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end

      default: state_nxt = S_HALT;
    endcase
  end

`ifdef RISC_CTRL_ICOUNT_EN
  // Every return to S_FET1 (other than the start-up one) retires an instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
    end else if ((state_nxt == S_FET1) && (state != S_IDLE) && (state != S_FET1)) begin
      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_risc_spm_ctrl.sv
// Bench for risc_spm_ctrl: a small RISC_SPM datapath reacts to the DUT's controls, and every
// cycle's control word plus every instruction's architectural result is compared to an ISA model.
// Backpressure: n/a.
module tb_risc_spm_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       write, halted;
`ifdef RISC_CTRL_ICOUNT_EN
  localparam int CW = 4;
  logic [CW-1:0] instr_count;
`endif

  int total = 0;
  int bad   = 0;

  risc_spm_ctrl #(
    .word_size(8),
    .Sel1_size(3),
    .Sel2_size(2)
`ifdef RISC_CTRL_ICOUNT_EN
    ,
    .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC), .Load_IR(Load_IR), .Load_Add_R(Load_Add_R),
    .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .write(write), .halted(halted)
`ifdef RISC_CTRL_ICOUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word: {Load_R3..R0, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel1, Sel2, write, halted}
  logic [16:0] ctl;
  assign ctl = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Load_IR, Load_Add_R,
                Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted};

  localparam logic [5:0] F_LPC = 6'b100000, F_IPC = 6'b010000, F_LIR = 6'b001000;
  localparam logic [5:0] F_LAR = 6'b000100, F_LY  = 6'b000010, F_LZ  = 6'b000001;
  localparam logic [2:0] B1_PC = 3'd4;
  localparam logic [1:0] B2_ALU = 2'd0, B2_B1 = 2'd1, B2_MEM = 2'd2;

  // Datapath state and its next values.
  logic [7:0] r[4];
  logic [7:0] pc, ir, ar, y;
  logic       zf;
  logic [7:0] mem[256];
  logic [7:0] r_n[4];
  logic [7:0] pc_n, ir_n, ar_n, y_n;
  logic       zf_n, mem_we;
  logic [7:0] mem_wa, mem_wd;
  int         cnt_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic [3:0] ldr, input logic [5:0] f,
                                     input logic [2:0] s1, input logic [1:0] s2,
                                     input logic wr, input logic h);
    return {ldr, f, s1, s2, wr, h};
  endfunction

  // Cycles from S_FET1 back to S_FET1 for one instruction.
  function automatic int pass_len(input logic [7:0] w, input logic z);
    case (w[7:4])
      4'd1, 4'd2, 4'd3:       return 4;
      4'd5, 4'd6, 4'd7:       return 5;
      4'd8:                   return z ? 5 : 3;
      default:                return 3;
    endcase
  endfunction

  // Expected control word in cycle k of the pass for instruction w (k=0 is S_FET1).
  function automatic logic [16:0] exp_ctl(input logic [7:0] w, input logic z, input int k);
    logic [3:0] op, dm;
    logic [2:0] s, d;
    logic       brlike;
    op = w[7:4];
    s  = {1'b0, w[3:2]};
    d  = {1'b0, w[1:0]};
    dm = 4'b0001 << w[1:0];
    brlike = (op == 4'd7) || (op == 4'd8 && z);
    if (k == 0) return mk(4'b0, F_LAR, B1_PC, B2_B1, 1'b0, 1'b0);
    if (k == 1) return mk(4'b0, F_LIR | F_IPC, 3'd0, B2_MEM, 1'b0, 1'b0);
    if (op > 4'd8) return (k == 2) ? 17'h0 : mk(4'b0, 6'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    if (k == 2) begin
      if (op >= 4'd1 && op <= 4'd3) return mk(4'b0, F_LY, s, B2_B1, 1'b0, 1'b0);
      if (op == 4'd4) return mk(dm, F_LZ, s, B2_ALU, 1'b0, 1'b0);
      if (op == 4'd5 || op == 4'd6 || brlike) return mk(4'b0, F_LAR, B1_PC, B2_B1, 1'b0, 1'b0);
      if (op == 4'd8) return mk(4'b0, F_IPC, 3'd0, 2'd0, 1'b0, 1'b0);
      return 17'h0;
    end
    if (k == 3) begin
      if (op >= 4'd1 && op <= 4'd3) return mk(dm, F_LZ, d, B2_ALU, 1'b0, 1'b0);
      if (op == 4'd5 || op == 4'd6) return mk(4'b0, F_LAR | F_IPC, 3'd0, B2_MEM, 1'b0, 1'b0);
      if (brlike) return mk(4'b0, F_LAR, 3'd0, B2_MEM, 1'b0, 1'b0);
      return 17'h0;
    end
    if (k == 4) begin
      if (op == 4'd5) return mk(dm, 6'b0, 3'd0, B2_MEM, 1'b0, 1'b0);
      if (op == 4'd6) return mk(4'b0, 6'b0, s, 2'd0, 1'b1, 1'b0);
      if (brlike) return mk(4'b0, F_LPC, 3'd0, B2_MEM, 1'b0, 1'b0);
    end
    return 17'h0;
  endfunction

  // Datapath reaction to the DUT's current controls (ALU: Y op Bus_1).
  task automatic dp_compute();
    logic [7:0] bus1, alu, bus2;
    case (Sel_Bus_1_Mux)
      3'd0: bus1 = r[0];
      3'd1: bus1 = r[1];
      3'd2: bus1 = r[2];
      3'd3: bus1 = r[3];
      3'd4: bus1 = pc;
      default: bus1 = 8'h00;
    endcase
    case (ir[7:4])
      4'd1: alu = y + bus1;
      4'd2: alu = bus1 - y;
      4'd3: alu = y & bus1;
      4'd4: alu = ~bus1;
      default: alu = 8'h00;
    endcase
    case (Sel_Bus_2_Mux)
      2'd0: bus2 = alu;
      2'd1: bus2 = bus1;
      2'd2: bus2 = mem[ar];
      default: bus2 = 8'h00;
    endcase
    r_n  = r;
    if (Load_R0) r_n[0] = bus2;
    if (Load_R1) r_n[1] = bus2;
    if (Load_R2) r_n[2] = bus2;
    if (Load_R3) r_n[3] = bus2;
    pc_n = pc;
    if (Load_PC) pc_n = bus2;
    if (Inc_PC)  pc_n = pc + 8'd1;
    ir_n   = Load_IR ? bus2 : ir;
    ar_n   = Load_Add_R ? bus2 : ar;
    y_n    = Load_Reg_Y ? bus2 : y;
    zf_n   = Load_Reg_Z ? (alu == 8'h00) : zf;
    mem_we = write;
    mem_wa = ar;
    mem_wd = bus1;
  endtask

  task automatic dp_apply();
    r  = r_n;
    pc = pc_n;
    ir = ir_n;
    ar = ar_n;
    y  = y_n;
    zf = zf_n;
    if (mem_we) mem[mem_wa] = mem_wd;
    instruction = ir;
    zero        = zf;
  endtask

  // Async reset asserted now; checks outputs drop immediately and the FSM restarts one cycle after release.
  task automatic reset_seq();
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl), 32'h0);
    cnt_m = 0;
`ifdef RISC_CTRL_ICOUNT_EN
    chk("rst_count", 32'(instr_count), 32'h0);
`endif
    @(posedge clk); #1;
    chk("rst_hold_ctl", 32'(ctl), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ctl", 32'(ctl), 32'h0);
    @(posedge clk); #1;
  endtask

  // One instruction from the word at mem[pc]; abort_k >= 0 pulls reset in that cycle.
  task automatic run_pass(input int abort_k);
    logic [7:0] w, opnd, epc, ewa, ewd;
    logic [7:0] er[4];
    logic       z0, ez, ew;
    logic [1:0] s, d;
    int         n;
    w    = mem[pc];
    opnd = mem[pc + 8'd1];
    z0   = zf;
    s    = w[3:2];
    d    = w[1:0];
    n    = pass_len(w, z0);
    er   = r;
    ez   = zf;
    ew   = 1'b0;
    ewa  = 8'h00;
    ewd  = 8'h00;
    epc  = pc + 8'd1;
    case (w[7:4])
      4'd1: begin er[d] = r[d] + r[s]; ez = (er[d] == 8'h00); end
      4'd2: begin er[d] = r[d] - r[s]; ez = (er[d] == 8'h00); end
      4'd3: begin er[d] = r[d] & r[s]; ez = (er[d] == 8'h00); end
      4'd4: begin er[d] = ~r[s];       ez = (er[d] == 8'h00); end
      4'd5: begin er[d] = mem[opnd]; epc = pc + 8'd2; end
      4'd6: begin ew = 1'b1; ewa = opnd; ewd = r[s]; epc = pc + 8'd2; end
      4'd7: epc = mem[opnd];
      4'd8: epc = z0 ? mem[opnd] : pc + 8'd2;
      default: ;
    endcase
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("ctl w=%02h k=%0d", w, k), 32'(ctl), 32'(exp_ctl(w, z0, k)));
      if (k == abort_k) begin
        reset_seq();
        chk("fet1_after_release", 32'(ctl), 32'(exp_ctl(8'h00, 1'b0, 0)));
        return;
      end
      dp_compute();
      @(posedge clk); #1;
      dp_apply();
    end
    for (int i = 0; i < 4; i++) chk($sformatf("r%0d w=%02h", i, w), 32'(r[i]), 32'(er[i]));
    chk($sformatf("pc w=%02h", w), 32'(pc), 32'(epc));
    chk($sformatf("z w=%02h", w), 32'(zf), 32'(ez));
    if (ew) chk($sformatf("mem[%02h] w=%02h", ewa, w), 32'(mem[ewa]), 32'(ewd));
    if (w[7:4] <= 4'd8) cnt_m++;
`ifdef RISC_CTRL_ICOUNT_EN
    chk("instr_count", 32'(instr_count), 32'(cnt_m % (1 << CW)));
`endif
  endtask

  initial begin
    rst = 1'b1;
    instruction = 8'h00;
    zero = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; ir = 8'h00; ar = 8'h00; y = 8'h00; zf = 1'b0;
    cnt_m = 0;
    #2;
    reset_seq();

    // RD R1 -> R2 from address 0x80.
    mem[8'h00] = 8'h56; mem[8'h01] = 8'h80; mem[8'h80] = 8'h3C;
    run_pass(-1);
    chk("t2_r2", 32'(r[2]), 32'h3C);
    chk("t2_pc", 32'(pc), 32'h02);

    // ADD R0 into R1.
    r[0] = 8'h05; r[1] = 8'h03;
    mem[8'h02] = 8'h11;
    run_pass(-1);
    chk("t3_r1", 32'(r[1]), 32'h08);
    chk("t3_z", 32'(zf), 32'h0);

    // BRZ not taken, then taken.
    pc = 8'h04; zf = 1'b0; zero = 1'b0;
    mem[8'h04] = 8'h80; mem[8'h05] = 8'h80;
    run_pass(-1);
    chk("t4_pc_nt", 32'(pc), 32'h06);
    zf = 1'b1; zero = 1'b1;
    mem[8'h06] = 8'h80; mem[8'h07] = 8'h20; mem[8'h20] = 8'h20;
    run_pass(-1);
    chk("t4_pc_tk", 32'(pc), 32'h20);

    // Reset in the middle of S_EX1 of an ADD.
    mem[pc] = 8'h11;
    run_pass(3);

`ifdef RISC_CTRL_ICOUNT_EN
    reset_seq();
    for (int i = 0; i < 3; i++) begin mem[pc] = 8'h00; run_pass(-1); end
    mem[pc] = 8'h61; mem[pc + 8'd1] = 8'h90;
    run_pass(-1);
    chk("t6_count4", 32'(instr_count), 32'h4);
    for (int i = 0; i < 12; i++) begin mem[pc] = 8'h00; run_pass(-1); end
    chk("t6_wrap", 32'(instr_count), 32'h0);
`endif

    // Random instruction stream over the legal opcodes.
    for (int p = 0; p < 150; p++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 8));
      mem[pc] = {op, 4'($urandom)};
      mem[pc + 8'd1] = 8'($urandom);
      if (op == 4'd8) begin zf = 1'($urandom); zero = zf; end
      if (p % 16 == 0) for (int i = 0; i < 4; i++) r[i] = 8'($urandom);
      run_pass(-1);
    end

    // Illegal opcode: halt and stay halted.
    mem[pc] = 8'hF0;
    run_pass(-1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_ctl", 32'(ctl), 32'h1);
`ifdef RISC_CTRL_ICOUNT_EN
      chk("halt_count", 32'(instr_count), 32'(cnt_m % (1 << CW)));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
